// File: rtl/ceas_alarma_if.sv
// Time-setting bus between the setting block and the clock/alarm core.
// The setting side drives the requests; the core returns time and alarm state.
interface ceas_alarma_if;
  logic [4:0] ore_in;
  logic [5:0] minute_in;
  logic       load_timp;
  logic       load_alarma;
  logic       oprire_alarma;
  logic [4:0] ore;
  logic [5:0] minute;
  logic [5:0] secunde;
  logic [4:0] ore_alarma;
  logic [5:0] minute_alarma;
  logic       alarma_armata;
  logic       alarma_suna;
  logic       puls_secunda;

  modport master (
    output ore_in, minute_in, load_timp, load_alarma, oprire_alarma,
    input  ore, minute, secunde, ore_alarma, minute_alarma,
    input  alarma_armata, alarma_suna, puls_secunda
  );

  modport slave (
    input  ore_in, minute_in, load_timp, load_alarma, oprire_alarma,
    output ore, minute, secunde, ore_alarma, minute_alarma,
    output alarma_armata, alarma_suna, puls_secunda
  );
endinterface

// File: rtl/ceas_alarma.sv
// HH:MM:SS clock with loadable time and a single daily alarm.
// Loads act on rising edges of level requests; all outputs are registered.
module ceas_alarma #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ALARM_DUR_SEC = 60
) (
  input logic          clock,
  input logic          reset,
  ceas_alarma_if.slave bus
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_TERM = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0] RING_LAST = 8'(ALARM_DUR_SEC - 1);

  typedef enum logic [1:0] {
    DEZARMAT = 2'd0,
    ARMAT    = 2'd1,
    SUNA     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [4:0]    ore_q, ore_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [4:0]    al_ore_q, al_ore_d;
  logic [5:0]    al_min_q, al_min_d;
  logic [7:0]    ring_q, ring_d;
  logic          lt_prev_q, la_prev_q;
  logic          puls_q, puls_d;

  logic tick, tick_eff, lt_ok, la_ok, in_ok, trig;

  always_comb begin
    in_ok = (bus.ore_in <= 5'd23) && (bus.minute_in <= 6'd59);
    lt_ok = bus.load_timp & ~lt_prev_q & in_ok;
    la_ok = bus.load_alarma & ~la_prev_q & in_ok;
    tick = (ps_q == PS_TERM);
    // A valid time load restarts the second, so a coincident tick is lost
    tick_eff = tick & ~lt_ok;
    puls_d = tick_eff;

    ps_d  = tick ? '0 : ps_q + PW'(1);
    ore_d = ore_q;
    min_d = min_q;
    sec_d = sec_q;
    if (lt_ok) begin
      ore_d = bus.ore_in;
      min_d = bus.minute_in;
      sec_d = '0;
      ps_d  = '0;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          ore_d = (ore_q == 5'd23) ? 5'd0 : ore_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    al_ore_d = la_ok ? bus.ore_in : al_ore_q;
    al_min_d = la_ok ? bus.minute_in : al_min_q;

    trig = tick_eff && (sec_d == 6'd0) &&
           (ore_d == al_ore_q) && (min_d == al_min_q);
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    if (la_ok) begin
      state_d = ARMAT;
      ring_d  = '0;
    end else begin
      unique case (state_q)
        DEZARMAT: ;
        ARMAT: begin
          if (trig && !bus.oprire_alarma) begin
            state_d = SUNA;
            ring_d  = '0;
          end
        end
        SUNA: begin
          if (bus.oprire_alarma) begin
            state_d = ARMAT;
          end else if (tick_eff) begin
            if (ring_q == RING_LAST) state_d = ARMAT;
            else ring_d = ring_q + 8'd1;
          end
        end
        default: state_d = DEZARMAT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= DEZARMAT;
      ps_q      <= '0;
      ore_q     <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      al_ore_q  <= '0;
      al_min_q  <= '0;
      ring_q    <= '0;
      lt_prev_q <= 1'b0;
      la_prev_q <= 1'b0;
      puls_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      ore_q     <= ore_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      al_ore_q  <= al_ore_d;
      al_min_q  <= al_min_d;
      ring_q    <= ring_d;
      lt_prev_q <= bus.load_timp;
      la_prev_q <= bus.load_alarma;
      puls_q    <= puls_d;
    end
  end

  assign bus.ore           = ore_q;
  assign bus.minute        = min_q;
  assign bus.secunde       = sec_q;
  assign bus.ore_alarma    = al_ore_q;
  assign bus.minute_alarma = al_min_q;
  assign bus.alarma_armata = (state_q != DEZARMAT);
  assign bus.alarma_suna   = (state_q == SUNA);
  assign bus.puls_secunda  = puls_q;

endmodule

// File: tb/tb_ceas_alarma.sv
// Bench for ceas_alarma: directed scenarios plus random traffic
// compared against a seconds-of-day reference model.
module tb_ceas_alarma;

  localparam int T   = 4;
  localparam int DUR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  ceas_alarma_if bus ();

  ceas_alarma #(
    .TICKS_PER_SEC(T),
    .ALARM_DUR_SEC(DUR)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int m_sod, m_phase, m_alh, m_alm, m_elapsed;
  bit m_armed, m_ring, m_pulse, m_pt, m_pa;

  task automatic model_reset();
    m_sod = 0; m_phase = 0; m_alh = 0; m_alm = 0; m_elapsed = 0;
    m_armed = 0; m_ring = 0; m_pulse = 0; m_pt = 0; m_pa = 0;
  endtask

  task automatic model_step();
    bit tl, la, vld, tk, tke;
    if (rst) begin
      model_reset();
    end else begin
      vld = (bus.ore_in < 24) && (bus.minute_in < 60);
      tl = bus.load_timp && !m_pt && vld;
      la = bus.load_alarma && !m_pa && vld;
      m_pt = bus.load_timp;
      m_pa = bus.load_alarma;
      tk = (m_phase == T - 1);
      tke = 0;
      if (tl) begin
        m_sod = int'(bus.ore_in) * 3600 + int'(bus.minute_in) * 60;
        m_phase = 0;
      end else begin
        m_phase = tk ? 0 : m_phase + 1;
        if (tk) begin
          m_sod = (m_sod + 1) % 86400;
          tke = 1;
        end
      end
      m_pulse = tke;
      if (la) begin
        m_alh = int'(bus.ore_in);
        m_alm = int'(bus.minute_in);
        m_armed = 1;
        m_ring = 0;
      end else if (m_ring) begin
        if (bus.oprire_alarma) m_ring = 0;
        else if (tke) begin
          m_elapsed++;
          if (m_elapsed == DUR) m_ring = 0;
        end
      end else if (m_armed && tke && !bus.oprire_alarma &&
                   m_sod == m_alh * 3600 + m_alm * 60) begin
        m_ring = 1;
        m_elapsed = 0;
      end
    end
  endtask

  function automatic logic [30:0] dut_vec();
    return {bus.ore, bus.minute, bus.secunde, bus.ore_alarma,
            bus.minute_alarma, bus.alarma_armata, bus.alarma_suna,
            bus.puls_secunda};
  endfunction

  function automatic logic [30:0] exp_vec();
    return {5'(m_sod / 3600), 6'((m_sod / 60) % 60), 6'(m_sod % 60),
            5'(m_alh), 6'(m_alm), m_armed, m_ring, m_pulse};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ore_in = '0; bus.minute_in = '0;
    bus.load_timp = 0; bus.load_alarma = 0; bus.oprire_alarma = 0;
    model_reset();
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic load_time(input int h, input int m);
    bus.ore_in = 5'(h); bus.minute_in = 6'(m);
    bus.load_timp = 1'b1;
    cyc();
    bus.load_timp = 1'b0;
    cyc();
  endtask

  task automatic load_alarm(input int h, input int m);
    bus.ore_in = 5'(h); bus.minute_in = 6'(m);
    bus.load_alarma = 1'b1;
    cyc();
    bus.load_alarma = 1'b0;
    cyc();
  endtask

  task automatic run_until(input int h, input int m, input int s);
    int n = 0;
    while (m_sod != h * 3600 + m * 60 + s && n < 2000) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec() !== 31'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", dut_vec());
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 240; i++) begin
      cyc();
      total++;
      if (bus.puls_secunda !== ((i % 4) == 3)) begin
        bad++;
        $display("FAIL puls cyc=%0d got=%0b exp=%0b",
                 i, bus.puls_secunda, (i % 4) == 3);
      end
    end
    total++;
    if (bus.minute !== 6'd1 || bus.secunde !== 6'd0 || bus.ore !== 5'd0) begin
      bad++;
      $display("FAIL free_run got=%0d:%0d:%0d exp=0:1:0",
               bus.ore, bus.minute, bus.secunde);
    end
  endtask

  task automatic test_wrap();
    bus.ore_in = 5'd23; bus.minute_in = 6'd59;
    bus.load_timp = 1'b1;
    cyc();
    total++;
    if (bus.ore !== 5'd23 || bus.minute !== 6'd59 || bus.secunde !== 6'd0) begin
      bad++;
      $display("FAIL wrap_load got=%0d:%0d:%0d exp=23:59:0",
               bus.ore, bus.minute, bus.secunde);
    end
    repeat (240) cyc();
    total++;
    if (bus.ore !== 5'd0 || bus.minute !== 6'd0 || bus.secunde !== 6'd0) begin
      bad++;
      $display("FAIL wrap_midnight got=%0d:%0d:%0d exp=0:0:0",
               bus.ore, bus.minute, bus.secunde);
    end
    bus.load_timp = 1'b0;
    cyc();
  endtask

  task automatic test_invalid();
    do_reset();
    load_time(24, 10);
    total++;
    if (bus.ore !== 5'd0 || bus.minute !== 6'd0) begin
      bad++;
      $display("FAIL bad_time got=%0d:%0d exp=0:0", bus.ore, bus.minute);
    end
    load_alarm(12, 60);
    total++;
    if (bus.ore_alarma !== 5'd0 || bus.minute_alarma !== 6'd0 ||
        bus.alarma_armata !== 1'b0) begin
      bad++;
      $display("FAIL bad_alarm got=%0d:%0d arm=%0b exp=0:0 arm=0",
               bus.ore_alarma, bus.minute_alarma, bus.alarma_armata);
    end
  endtask

  task automatic test_alarm_ring();
    load_alarm(10, 5);
    load_time(10, 4);
    run_until(10, 5, 0);
    total++;
    if (bus.ore !== 5'd10 || bus.minute !== 6'd5 || bus.secunde !== 6'd0 ||
        bus.alarma_suna !== 1'b1) begin
      bad++;
      $display("FAIL ring_start got=%0d:%0d:%0d suna=%0b exp=10:5:0 suna=1",
               bus.ore, bus.minute, bus.secunde, bus.alarma_suna);
    end
    run_until(10, 5, 2);
    total++;
    if (bus.alarma_suna !== 1'b1) begin
      bad++;
      $display("FAIL ring_hold got=%0b exp=1", bus.alarma_suna);
    end
    run_until(10, 5, 3);
    total++;
    if (bus.alarma_suna !== 1'b0 || bus.alarma_armata !== 1'b1) begin
      bad++;
      $display("FAIL ring_timeout suna=%0b arm=%0b exp suna=0 arm=1",
               bus.alarma_suna, bus.alarma_armata);
    end
  endtask

  task automatic test_stop();
    load_time(10, 4);
    run_until(10, 5, 0);
    total++;
    if (bus.alarma_suna !== 1'b1) begin
      bad++;
      $display("FAIL stop_pre got=%0b exp=1", bus.alarma_suna);
    end
    bus.oprire_alarma = 1'b1;
    cyc();
    bus.oprire_alarma = 1'b0;
    total++;
    if (bus.alarma_suna !== 1'b0 || bus.alarma_armata !== 1'b1) begin
      bad++;
      $display("FAIL stop suna=%0b arm=%0b exp suna=0 arm=1",
               bus.alarma_suna, bus.alarma_armata);
    end
    run_until(10, 5, 2);
    total++;
    if (bus.secunde !== 6'd2 || bus.alarma_suna !== 1'b0) begin
      bad++;
      $display("FAIL stop_run sec=%0d suna=%0b exp sec=2 suna=0",
               bus.secunde, bus.alarma_suna);
    end
  endtask

  task automatic test_reset_ringing();
    load_time(10, 4);
    run_until(10, 5, 1);
    total++;
    if (bus.alarma_suna !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset suna=%0b exp=1", bus.alarma_suna);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (dut_vec() !== 31'd0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", dut_vec());
    end
    model_reset();
    @(negedge clk);
    cyc();
    rst = 1'b0;
    while (m_phase != T - 1) cyc();
    bus.ore_in = 5'd7; bus.minute_in = 6'd30;
    bus.load_timp = 1'b1;
    cyc();
    bus.load_timp = 1'b0;
    total++;
    if (bus.ore !== 5'd7 || bus.minute !== 6'd30 || bus.secunde !== 6'd0 ||
        bus.puls_secunda !== 1'b0) begin
      bad++;
      $display("FAIL load_tick got=%0d:%0d:%0d p=%0b exp=7:30:0 p=0",
               bus.ore, bus.minute, bus.secunde, bus.puls_secunda);
    end
    repeat (3) cyc();
    total++;
    if (bus.secunde !== 6'd0) begin
      bad++;
      $display("FAIL load_ps_clr got=%0d exp=0", bus.secunde);
    end
    cyc();
    total++;
    if (bus.secunde !== 6'd1) begin
      bad++;
      $display("FAIL load_ps_next got=%0d exp=1", bus.secunde);
    end
  endtask

  task automatic test_random();
    int h, mi;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) bus.load_timp = ~bus.load_timp;
      if ($urandom_range(0, 29) == 0) bus.load_alarma = ~bus.load_alarma;
      bus.oprire_alarma = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0: begin
          bus.ore_in = 5'($urandom_range(0, 31));
          bus.minute_in = 6'($urandom_range(0, 63));
        end
        1, 2: begin
          h = m_sod / 3600;
          mi = (m_sod / 60) % 60 + int'($urandom_range(0, 1));
          bus.ore_in = 5'(h);
          bus.minute_in = 6'(mi);
        end
        default: ;
      endcase
      cyc();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_wrap();
    test_invalid();
    test_alarm_ring();
    test_stop();
    test_reset_ringing();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
